// File: rtl/alu_pkg.sv
// Shared types for the ALU result path: flag layout and the buffered entry format.
package alu_pkg;

  // Bit positions of each flag inside a packed flag vector (zero is the LSB).
  localparam int FLAG_ZERO     = 0;
  localparam int FLAG_CARRY    = 1;
  localparam int FLAG_SIGN     = 2;
  localparam int FLAG_PARITY   = 3;
  localparam int FLAG_OVERFLOW = 4;
  localparam int FLAG_W        = 5;

  // Default ALU widths for users that do not override them.
  localparam int ALU_WIDTH = 8;
  localparam int ALU_SEL_W = 3;

  // Declaration order puts zero at bit 0, matching the FLAG_* indices.
  typedef struct packed {
    logic overflow;
    logic parity;
    logic sign;
    logic carry;
    logic zero;
  } alu_flags_t;

  // One captured ALU result at the default widths.
  typedef struct packed {
    logic [ALU_SEL_W-1:0] select;
    logic [ALU_WIDTH-1:0] data;
    alu_flags_t           flags;
  } alu_entry_t;

endpackage

// File: rtl/alu_sync_fifo.sv
// Generic valid/ready FIFO with a registered head entry and occupancy output.
// An entry written in cycle N is presented in cycle N+1; there is no bypass,
// and a full FIFO refuses writes even while it is being read.
module alu_sync_fifo #(
  parameter int ENTRY_W = 16,
  parameter int DEPTH   = 4,
  localparam int LVL_W  = $clog2(DEPTH + 1),
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ENTRY_W-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ENTRY_W-1:0] out_data,
  output logic [LVL_W-1:0]   level
);

  logic [ENTRY_W-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
  logic [LVL_W-1:0]   level_reg, level_next;
  logic [ENTRY_W-1:0] head_reg, head_next;
  logic               out_valid_reg;
  logic               push, pop, drained;

  assign in_ready  = (level_reg != LVL_W'(DEPTH));
  assign push      = in_valid && in_ready;
  assign pop       = out_valid_reg && out_ready;
  assign out_valid = out_valid_reg;
  assign out_data  = head_reg;
  assign level     = level_reg;

  // Next occupancy, read pointer and head entry. When the stored entries run
  // out this cycle, the head can only come from the entry being written now.
  always_comb begin
    rd_ptr_next = rd_ptr_reg + PTR_W'(pop);
    level_next  = level_reg;
    if (push && !pop) begin
      level_next = level_reg + LVL_W'(1);
    end else if (pop && !push) begin
      level_next = level_reg - LVL_W'(1);
    end
    drained   = (level_reg == '0) || (pop && level_reg == LVL_W'(1));
    head_next = head_reg;
    if (drained) begin
      if (push) begin
        head_next = in_data;
      end
    end else begin
      head_next = mem_reg[rd_ptr_next];
    end
  end

  // Entry storage; contents are meaningless until written, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_reg[wr_ptr_reg] <= in_data;
    end
  end

  // Pointers, occupancy and the registered head presented to the consumer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      level_reg     <= '0;
      out_valid_reg <= 1'b0;
      head_reg      <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      rd_ptr_reg    <= rd_ptr_next;
      level_reg     <= level_next;
      out_valid_reg <= (level_next != '0);
      head_reg      <= head_next;
    end
  end

endmodule

// File: rtl/alu_result_buffer.sv
// Buffers ALU results (data, opcode tag, flags) for an in-order consumer and
// keeps sticky carry/overflow bits plus a saturating accepted-result count.
module alu_result_buffer
  import alu_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int SEL_W  = 3,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 16,
  localparam int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SEL_W-1:0] in_select,
  input  logic [WIDTH-1:0] in_out,
  input  logic             in_zero,
  input  logic             in_carry,
  input  logic             in_sign,
  input  logic             in_parity,
  input  logic             in_overflow,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [SEL_W-1:0] out_select,
  output logic [4:0]       out_flags,
  output logic [LVL_W-1:0] level,
  output logic             sticky_carry,
  output logic             sticky_overflow,
  input  logic             clear_sticky,
  output logic [CNT_W-1:0] result_count
);

  // Same layout as alu_entry_t, but sized by this instance's parameters.
  typedef struct packed {
    logic [SEL_W-1:0] select;
    logic [WIDTH-1:0] data;
    alu_flags_t       flags;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

  logic [FLAG_W-1:0] in_flag_vec;
  entry_t            wr_entry, rd_entry;
  logic              push;
  logic              sticky_carry_reg, sticky_overflow_reg;
  logic [CNT_W-1:0]  count_reg;

  // Pack the incoming ALU result into one FIFO entry.
  always_comb begin
    in_flag_vec                = '0;
    in_flag_vec[FLAG_ZERO]     = in_zero;
    in_flag_vec[FLAG_CARRY]    = in_carry;
    in_flag_vec[FLAG_SIGN]     = in_sign;
    in_flag_vec[FLAG_PARITY]   = in_parity;
    in_flag_vec[FLAG_OVERFLOW] = in_overflow;
    wr_entry.select            = in_select;
    wr_entry.data              = in_out;
    wr_entry.flags             = alu_flags_t'(in_flag_vec);
  end

  alu_sync_fifo #(
    .ENTRY_W (ENTRY_W),
    .DEPTH   (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (wr_entry),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (rd_entry),
    .level     (level)
  );

  assign push            = in_valid && in_ready;
  assign out_data        = rd_entry.data;
  assign out_select      = rd_entry.select;
  assign out_flags       = rd_entry.flags;
  assign sticky_carry    = sticky_carry_reg;
  assign sticky_overflow = sticky_overflow_reg;
  assign result_count    = count_reg;

  // Sticky flags: a flagged push wins over a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_carry_reg    <= 1'b0;
      sticky_overflow_reg <= 1'b0;
    end else begin
      sticky_carry_reg    <= (sticky_carry_reg && !clear_sticky) ||
                             (push && wr_entry.flags.carry);
      sticky_overflow_reg <= (sticky_overflow_reg && !clear_sticky) ||
                             (push && wr_entry.flags.overflow);
    end
  end

  // Accepted-result counter, holding at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (push && (count_reg != '1)) begin
      count_reg <= count_reg + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_alu_result_buffer.sv
// Scoreboard bench for alu_result_buffer: a queue-based reference model
// tracks accepted entries, sticky bits and the count; a negedge monitor
// compares DUT state and popped entries against it.
module tb_alu_result_buffer;
  import alu_pkg::*;

  localparam int WIDTH = 8;
  localparam int SEL_W = 3;
  localparam int DEPTH = 4;
  localparam int CNT_W = 16;
  localparam int LVL_W = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [SEL_W-1:0] in_select = '0;
  logic [WIDTH-1:0] in_out = '0;
  logic             in_zero = 1'b0, in_carry = 1'b0, in_sign = 1'b0;
  logic             in_parity = 1'b0, in_overflow = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic [SEL_W-1:0] out_select;
  logic [4:0]       out_flags;
  logic [LVL_W-1:0] level;
  logic             sticky_carry, sticky_overflow;
  logic             clear_sticky = 1'b0;
  logic [CNT_W-1:0] result_count;

  alu_result_buffer #(
    .WIDTH (WIDTH), .SEL_W (SEL_W), .DEPTH (DEPTH), .CNT_W (CNT_W)
  ) dut (
    .clk (clk), .rst_n (rst_n),
    .in_valid (in_valid), .in_ready (in_ready),
    .in_select (in_select), .in_out (in_out),
    .in_zero (in_zero), .in_carry (in_carry), .in_sign (in_sign),
    .in_parity (in_parity), .in_overflow (in_overflow),
    .out_valid (out_valid), .out_ready (out_ready),
    .out_data (out_data), .out_select (out_select), .out_flags (out_flags),
    .level (level),
    .sticky_carry (sticky_carry), .sticky_overflow (sticky_overflow),
    .clear_sticky (clear_sticky), .result_count (result_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [SEL_W-1:0] sel;
    logic [WIDTH-1:0] data;
    logic [4:0]       flags;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass = 0;
  logic m_sc = 1'b0, m_so = 1'b0;
  int   m_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
  endtask

  // Monitor and reference model: compare current state, then apply the
  // handshakes that the coming rising edge will perform.
  always @(negedge clk) begin
    if (rst_n) begin
      automatic bit push_exp;
      automatic exp_t e;
      check("level", 32'(level), 32'(sb_q.size()));
      check("level_bound", 32'(level <= LVL_W'(DEPTH)), 32'd1);
      check("out_valid", 32'(out_valid), 32'(sb_q.size() != 0));
      check("in_ready", 32'(in_ready), 32'(sb_q.size() < DEPTH));
      check("sticky_carry", 32'(sticky_carry), 32'(m_sc));
      check("sticky_overflow", 32'(sticky_overflow), 32'(m_so));
      check("result_count", 32'(result_count), 32'(m_cnt));
      push_exp = in_valid && (sb_q.size() < DEPTH);
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          $display("FAIL pop_empty: got out_valid=1, expected no entry at %0t", $time);
        end else begin
          e = sb_q.pop_front();
          $display("pop data=%02h sel=%0d flags=%05b", out_data, out_select, out_flags);
          check("pop_data", 32'(out_data), 32'(e.data));
          check("pop_select", 32'(out_select), 32'(e.sel));
          check("pop_flags", 32'(out_flags), 32'(e.flags));
        end
      end
      if (push_exp) begin
        e.sel   = in_select;
        e.data  = in_out;
        e.flags = {in_overflow, in_parity, in_sign, in_carry, in_zero};
        sb_q.push_back(e);
        if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
      end
      m_sc = (m_sc && !clear_sticky) || (push_exp && in_carry);
      m_so = (m_so && !clear_sticky) || (push_exp && in_overflow);
    end
  end

  // Drive one cycle of inputs; returns just after the rising edge.
  task automatic drive(input logic v, input logic [WIDTH-1:0] d, input logic [SEL_W-1:0] s,
                       input logic [4:0] f, input logic rdy, input logic clr);
    in_valid     = v;
    in_out       = d;
    in_select    = s;
    {in_overflow, in_parity, in_sign, in_carry, in_zero} = f;
    out_ready    = rdy;
    clear_sticky = clr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_count", 32'(result_count), 32'd0);
    check("rst_sticky", 32'({sticky_carry, sticky_overflow}), 32'd0);
    check("rst_out", 32'({out_data, out_select, out_flags}), 32'd0);
    rst_n = 1'b1;
    repeat (5) drive(0, 8'h00, 3'd0, 5'b0, 0, 0);

    // Single push with carry, held at the output
    drive(1, 8'hA5, 3'd2, 5'b00010, 0, 0);
    check("tp_valid", 32'(out_valid), 32'd1);
    check("tp_data", 32'(out_data), 32'hA5);
    check("tp_select", 32'(out_select), 32'd2);
    check("tp_flags", 32'(out_flags), 32'b00010);
    check("tp_sticky_carry", 32'(sticky_carry), 32'd1);
    check("tp_count", 32'(result_count), 32'd1);
    drive(0, 8'h00, 3'd0, 5'b0, 0, 0);
    check("tp_hold", 32'(out_data), 32'hA5);
    drive(0, 8'h00, 3'd0, 5'b0, 1, 0);

    // Fill to full, refuse an extra entry, then drain in order
    for (int i = 1; i <= 4; i++) drive(1, 8'(i), 3'(i), 5'(i), 0, 0);
    check("full_level", 32'(level), 32'd4);
    check("full_in_ready", 32'(in_ready), 32'd0);
    drive(1, 8'h55, 3'd7, 5'b11111, 0, 0);
    drive(1, 8'h66, 3'd6, 5'b0, 1, 0);
    check("full_pop_no_push", 32'(level), 32'd3);
    repeat (4) drive(0, 8'h00, 3'd0, 5'b0, 1, 0);
    check("drain_level", 32'(level), 32'd0);

    // Streaming push and pop every cycle
    drive(1, 8'h10, 3'd1, 5'b0, 1, 0);
    for (int i = 1; i <= 20; i++) drive(1, 8'(8'h10 + i), 3'(i), 5'(i * 3), 1, 0);
    drive(0, 8'h00, 3'd0, 5'b0, 1, 0);

    // Clear racing a flagged push leaves sticky set; clear alone drops it
    drive(0, 8'h00, 3'd0, 5'b0, 0, 1);
    drive(1, 8'h3C, 3'd5, 5'b10000, 1, 1);
    check("sticky_ov_race", 32'(sticky_overflow), 32'd1);
    drive(0, 8'h00, 3'd0, 5'b0, 1, 1);
    check("sticky_ov_clear", 32'(sticky_overflow), 32'd0);
    drive(0, 8'h00, 3'd0, 5'b0, 1, 0);

    // Asynchronous reset with three entries pending
    for (int i = 0; i < 3; i++) drive(1, 8'(8'hE0 + i), 3'd3, 5'b00001, 0, 0);
    check("pre_rst_level", 32'(level), 32'd3);
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(out_valid), 32'd0);
    check("async_rst_level", 32'(level), 32'd0);
    sb_q.delete();
    m_sc = 1'b0; m_so = 1'b0; m_cnt = 0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(1, 8'h77, 3'd4, 5'b01000, 0, 0);
    check("post_rst_head", 32'(out_data), 32'h77);
    drive(1, 8'h78, 3'd4, 5'b0, 1, 0);
    drive(0, 8'h00, 3'd0, 5'b0, 1, 0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 8'($urandom), 3'($urandom), 5'($urandom),
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 9) == 0));
    end
    repeat (DEPTH + 2) drive(0, 8'h00, 3'd0, 5'b0, 1, 0);
    check("final_empty", 32'(level), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
